// File: rtl/alu_flag_commit_stage.sv
// rtl/alu_flag_commit_stage.sv - ALU result/flag commit stage with 2-entry skid buffer and NZVC condition evaluation
// Optional macro FLAG_FORWARD_EN: cond_pass sees flags of a flag-setting entry retiring this cycle.
module alu_flag_commit_stage #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] in_result,
  input  logic [3:0]      in_flags_n_z_v_c,
  input  logic            in_set_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_result,
  output logic [3:0]      out_flags_n_z_v_c,
  output logic [3:0]      flags_reg_n_z_v_c,
  input  logic [3:0]      cond_code,
  output logic            cond_pass
);

  typedef struct packed {
    logic [size-1:0] result;
    logic [3:0]      flags;
    logic            set_flags;
  } entry_t;

  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     in_entry;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q;
  logic [3:0] flags_q, flags_d;
  logic [3:0] cond_flags;
  logic       accept;
  logic       retire;

  function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, v, c;
    logic res;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (cc)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign accept   = in_valid && in_ready_q;
  assign retire   = main_valid_q && out_ready;
  assign in_entry = {in_result, in_flags_n_z_v_c, in_set_flags};

  // The skid register only fills while main is stalled, so a full skid never coincides with an accept.
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!main_valid_q || (retire && !skid_valid_q)) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_entry;
      end
    end else if (retire) begin
      main_valid_d = 1'b1;
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = in_entry;
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (retire && main_q.set_flags) begin
      flags_d = main_q.flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
      flags_q      <= 4'b0000;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= !skid_valid_d;
      flags_q      <= flags_d;
    end
  end

`ifdef FLAG_FORWARD_EN
  assign cond_flags = (retire && main_q.set_flags) ? main_q.flags : flags_q;
`else
  assign cond_flags = flags_q;
`endif

  assign in_ready          = in_ready_q;
  assign out_valid         = main_valid_q;
  assign out_result        = main_q.result;
  assign out_flags_n_z_v_c = main_q.flags;
  assign flags_reg_n_z_v_c = flags_q;
  assign cond_pass         = eval_cond(cond_code, cond_flags);

endmodule
